mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences register-file load/store operations onto the single-ported data memory.
//  Arbitrates the memory between two requesters: the core (regfile loadEn/storEn path) and
//  the debug/init port. Presents a req/ack handshake toward memory and stalls the core until
//  the access completes. Sits between decode/register_file and data memory; posedge clk.
// PARAMETERS
//  ADDR_W   8    memory address width (core address comes from regfile M)
//  DATA_W   8    data width
//  TIMEOUT  15   max BUSY cycles without mem_ack before abort; >=1
// PORTS
//  clk          in   1       system clock, posedge
//  rst_n        in   1       asynchronous, active-low reset
//  core_load    in   1       core load request, level, held while core_stall=1
//  core_store   in   1       core store request, level, held while core_stall=1
//  core_addr    in   ADDR_W  core access address
//  core_wdata   in   DATA_W  core store data (regfile storData)
//  core_stall   out  1       core must hold its instruction
//  core_rdata   out  DATA_W  load data to regfile loadData; held until next core load completes
//  core_rvalid  out  1       1-cycle pulse: core_rdata valid, regfile writes dst
//  dbg_req      in   1       debug request, level, held until dbg_done
//  dbg_we       in   1       debug write(1)/read(0)
//  dbg_addr     in   ADDR_W  debug address
//  dbg_wdata    in   DATA_W  debug write data
//  dbg_rdata    out  DATA_W  debug read data, held until next debug read completes
//  dbg_done     out  1       1-cycle pulse: debug access complete (read or write)
//  mem_req      out  1       memory request, registered
//  mem_we       out  1       memory write enable, valid with mem_req
//  mem_addr     out  ADDR_W  memory address, valid with mem_req
//  mem_wdata    out  DATA_W  memory write data, valid with mem_req
//  mem_ack      in   1       memory completion; sampled only while mem_req=1
//  mem_rdata    in   DATA_W  read data, valid with mem_ack
//  err          out  1       sticky: timeout abort or core_load&core_store seen
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last-owner = DBG (core wins first tie); timeout counter 0.
//   Reset mid-access drops mem_req immediately; no done/rvalid pulse for the aborted access.
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: core request = core_load|core_store. If only one requester, grant it; if both,
//   grant the one not served last (round-robin). On grant latch owner, we, addr, wdata;
//   mem_req=1 and counter=0 from next cycle; go BUSY. No requester: stay IDLE.
//  core_load & core_store together: treat as load, set err.
//  BUSY: mem_req/mem_we/mem_addr/mem_wdata held stable. On mem_ack: capture mem_rdata
//   (reads only), drop mem_req next cycle, go RESP. Else counter++; counter==TIMEOUT with no ack:
//   drop mem_req, set err, complete with read data 8'hFF, go RESP.
//  RESP: exactly one cycle. Owner core: core_rvalid=1 if load; core_stall=0. Owner dbg: dbg_done=1.
//   Update last-owner. Next state IDLE; no new grant is issued from RESP.
//  core_stall = (core_load|core_store) & !(state==RESP & owner==CORE); combinational, so a
//   new core request stalls in its first cycle.
//  Min core latency: request cycle 0, mem_req cycle 1, ack cycle 1, RESP/stall low cycle 2.
//  Store completion: core_rvalid stays 0; completion is signalled by core_stall falling.
//  Back-to-back: a request still present in the IDLE cycle after RESP is a new access.
//  mem_ack outside BUSY is ignored. Requester inputs changing mid-access are ignored (latched).
//  Regfile samples on negedge; core_rdata/core_rvalid driven from posedge flops, stable at negedge.
// STRUCTURE
//  instr_pack additions: typedef enum logic[1:0] {MAC_IDLE, MAC_BUSY, MAC_RESP} mac_state_e;
//   typedef enum logic {OWN_CORE, OWN_DBG} mac_owner_e; localparam MAC_ABORT_DATA = 8'hFF.
//  Sub-module: mac_rr_arbiter (2 requesters, last-owner flop, grant valid only in IDLE).
//  Timeout counter width $clog2(TIMEOUT+1).
// TESTING
//  1 core_load addr 8'h10, mem_ack in cycle 1 with rdata 8'h5A -> mem_req cycles 1 only,
//    core_rvalid cycle 2 with core_rdata 8'h5A, core_stall 1 in cycles 0-1, 0 in cycle 2.
//  2 core_store addr 8'h20 wdata 8'hC3, ack after 3 cycles -> mem_we=1, addr/wdata stable
//    throughout BUSY, no core_rvalid, stall falls in RESP.
//  3 core_load and dbg_req (read 8'h30) asserted together from reset -> core served first,
//    then dbg; next tie -> dbg first (round-robin alternation over 4 ties).
//  4 no mem_ack for TIMEOUT cycles -> mem_req drops, err=1 sticky, core_rvalid with 8'hFF.
//  5 rst_n low during BUSY -> mem_req 0 immediately, no pulse; after release fresh load ok.
//  6 core_load & core_store together -> memory read performed, err=1.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        MAC_IDLE = 2'd0,
        MAC_BUSY = 2'd1,
        MAC_RESP = 2'd2
    } mac_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } mac_owner_e;

    localparam logic [7:0] MAC_ABORT_DATA = 8'hFF;

    // Requester that did not hold the memory last time
    function automatic mac_owner_e mac_other(input mac_owner_e owner);
        return (owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
    endfunction

endpackage

// File: rtl/mac_rr_arbiter.sv
// Two-way round-robin arbiter between core and debug requesters.
module mac_rr_arbiter
    import mem_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req_core,
    input  logic       i_req_dbg,
    input  logic       i_idle,
    input  logic       i_upd,
    input  mac_owner_e i_owner,
    output logic       o_gnt_c,
    output mac_owner_e o_owner_c
);

    mac_owner_e r_last;

    // Reset to DBG so the core wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= OWN_DBG;
        end else if (i_upd) begin
            r_last <= i_owner;
        end
    end

    always_comb begin
        o_gnt_c   = i_idle & (i_req_core | i_req_dbg);
        o_owner_c = OWN_CORE;
        if (i_req_core && i_req_dbg) begin
            o_owner_c = mac_other(r_last);
        end else if (i_req_dbg) begin
            o_owner_c = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences core and debug load/store requests onto the single-ported data memory.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_load,
    input  logic              core_store,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    mac_state_e        r_state, w_state_nxt;
    mac_owner_e        r_owner, w_owner_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic [DATA_W-1:0] r_core_rdata, w_core_rdata_nxt;
    logic              r_core_rvalid, w_core_rvalid_nxt;
    logic [DATA_W-1:0] r_dbg_rdata, w_dbg_rdata_nxt;
    logic              r_dbg_done, w_dbg_done_nxt;
    logic              r_err, w_err_nxt;

    logic              w_core_req;
    logic              w_gnt;
    mac_owner_e        w_gnt_owner;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;

    assign w_core_req = core_load | core_store;
    assign w_timeout  = (r_state == MAC_BUSY) & ~mem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_done     = (r_state == MAC_BUSY) & (mem_ack | w_timeout);
    assign w_rdata    = mem_ack ? mem_rdata : DATA_W'(MAC_ABORT_DATA);

    mac_rr_arbiter u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_core (w_core_req),
        .i_req_dbg  (dbg_req),
        .i_idle     (r_state == MAC_IDLE),
        .i_upd      (r_state == MAC_RESP),
        .i_owner    (r_owner),
        .o_gnt_c    (w_gnt),
        .o_owner_c  (w_gnt_owner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MAC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MAC_IDLE: if (w_gnt) w_state_nxt = MAC_BUSY;
            MAC_BUSY: if (w_done) w_state_nxt = MAC_RESP;
            MAC_RESP: w_state_nxt = MAC_IDLE;
            default:  w_state_nxt = MAC_IDLE;
        endcase
    end

    // Request latching on grant; completion pulses are registered on BUSY exit
    always_comb begin
        w_owner_nxt       = r_owner;
        w_we_nxt          = r_we;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_cnt_nxt         = r_cnt;
        w_mem_req_nxt     = r_mem_req;
        w_core_rdata_nxt  = r_core_rdata;
        w_core_rvalid_nxt = 1'b0;
        w_dbg_rdata_nxt   = r_dbg_rdata;
        w_dbg_done_nxt    = 1'b0;
        w_err_nxt         = r_err;
        case (r_state)
            MAC_IDLE: begin
                if (w_gnt) begin
                    w_owner_nxt   = w_gnt_owner;
                    w_mem_req_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    if (w_gnt_owner == OWN_CORE) begin
                        w_we_nxt    = core_store & ~core_load;
                        w_addr_nxt  = core_addr;
                        w_wdata_nxt = core_wdata;
                        if (core_load && core_store) w_err_nxt = 1'b1;
                    end else begin
                        w_we_nxt    = dbg_we;
                        w_addr_nxt  = dbg_addr;
                        w_wdata_nxt = dbg_wdata;
                    end
                end
            end
            MAC_BUSY: begin
                if (w_done) begin
                    w_mem_req_nxt = 1'b0;
                    if (w_timeout) w_err_nxt = 1'b1;
                    if (r_owner == OWN_CORE) begin
                        w_core_rvalid_nxt = ~r_we;
                        if (!r_we) w_core_rdata_nxt = w_rdata;
                    end else begin
                        w_dbg_done_nxt = 1'b1;
                        if (!r_we) w_dbg_rdata_nxt = w_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner       <= OWN_CORE;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_mem_req     <= 1'b0;
            r_core_rdata  <= '0;
            r_core_rvalid <= 1'b0;
            r_dbg_rdata   <= '0;
            r_dbg_done    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_owner       <= w_owner_nxt;
            r_we          <= w_we_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_cnt         <= w_cnt_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_core_rdata  <= w_core_rdata_nxt;
            r_core_rvalid <= w_core_rvalid_nxt;
            r_dbg_rdata   <= w_dbg_rdata_nxt;
            r_dbg_done    <= w_dbg_done_nxt;
            r_err         <= w_err_nxt;
        end
    end

    // Stall releases only in the core's own response cycle
    assign core_stall  = w_core_req & ~((r_state == MAC_RESP) & (r_owner == OWN_CORE));
    assign core_rdata  = r_core_rdata;
    assign core_rvalid = r_core_rvalid;
    assign dbg_rdata   = r_dbg_rdata;
    assign dbg_done    = r_dbg_done;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign err         = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed checks of mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int TO = 15;

    logic       clk, rst_n;
    logic       core_load, core_store, core_stall, core_rvalid;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       dbg_req, dbg_we, dbg_done;
    logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic       mem_req, mem_we, mem_ack, err;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_miss = 0;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_load(core_load), .core_store(core_store), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: one access in flight, owner 0 = core, 1 = debug
    bit         m_active, m_resp;
    int         m_owner, m_last, m_waited;
    bit         m_we;
    logic [7:0] m_addr, m_wdata;
    logic       e_mem_req, e_core_rvalid, e_dbg_done, e_err;
    logic [7:0] e_core_rdata, e_dbg_rdata;
    bit         core_released, dbg_released;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_resp = 0; m_owner = 0; m_last = 1; m_waited = 0;
        m_we = 0; m_addr = 8'h00; m_wdata = 8'h00;
        e_mem_req = 0; e_core_rvalid = 0; e_dbg_done = 0; e_err = 0;
        e_core_rdata = 8'h00; e_dbg_rdata = 8'h00;
        core_released = 0; dbg_released = 0;
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic model_update();
        bit         fin;
        bit         cr;
        logic [7:0] d;
        e_core_rvalid = 0; e_dbg_done = 0;
        core_released = 0; dbg_released = 0;
        fin = 0; d = 8'h00;
        cr = core_load | core_store;
        if (m_resp) begin
            m_last = m_owner;
            m_resp = 0;
            if (m_owner == 0) core_released = 1; else dbg_released = 1;
        end else if (m_active) begin
            if (mem_ack) begin
                fin = 1; d = mem_rdata;
            end else if (m_waited + 1 == TO) begin
                fin = 1; d = 8'hFF; e_err = 1;
            end else begin
                m_waited++;
            end
            if (fin) begin
                m_active = 0; m_resp = 1; e_mem_req = 0;
                if (m_owner == 0) begin
                    if (!m_we) begin e_core_rvalid = 1; e_core_rdata = d; end
                end else begin
                    e_dbg_done = 1;
                    if (!m_we) e_dbg_rdata = d;
                end
            end
        end else if (cr || dbg_req) begin
            if (cr && dbg_req) m_owner = 1 - m_last;
            else m_owner = cr ? 0 : 1;
            if (m_owner == 0) begin
                m_we = core_store && !core_load;
                m_addr = core_addr; m_wdata = core_wdata;
                if (core_load && core_store) e_err = 1;
            end else begin
                m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
            end
            m_active = 1; m_waited = 0; e_mem_req = 1;
        end
    endtask

    task automatic check_model();
        chk1("core_stall", core_stall, (core_load | core_store) && !(m_resp && m_owner == 0));
        chk1("core_rvalid", core_rvalid, e_core_rvalid);
        chk8("core_rdata", core_rdata, e_core_rdata);
        chk1("dbg_done", dbg_done, e_dbg_done);
        chk8("dbg_rdata", dbg_rdata, e_dbg_rdata);
        chk1("mem_req", mem_req, e_mem_req);
        chk1("err", err, e_err);
        if (e_mem_req) begin
            chk1("mem_we", mem_we, m_we);
            chk8("mem_addr", mem_addr, m_addr);
            chk8("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic drive(input logic cl, input logic cs, input logic [7:0] ca, input logic [7:0] cw,
                         input logic dr, input logic dwe, input logic [7:0] da, input logic [7:0] dwd,
                         input logic ack, input logic [7:0] rd);
        @(negedge clk);
        core_load = cl; core_store = cs; core_addr = ca; core_wdata = cw;
        dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
        mem_ack = ack; mem_rdata = rd;
        #1;
        check_model();
    endtask

    task automatic tick_upd();
        @(posedge clk);
        if (rst_n) model_update(); else model_reset();
    endtask

    task automatic zero_inputs();
        core_load = 0; core_store = 0; core_addr = 8'h00; core_wdata = 8'h00;
        dbg_req = 0; dbg_we = 0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        mem_ack = 0; mem_rdata = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        zero_inputs();
        #1;
        model_reset();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_core_rvalid", core_rvalid, 1'b0);
        chk1("rst_dbg_done", dbg_done, 1'b0);
        chk8("rst_core_rdata", core_rdata, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    bit         c_pend, d_pend;
    logic       p_cl, p_cs, p_dr, p_dwe, p_ack;
    logic [7:0] p_ca, p_cw, p_da, p_dwd;
    int         r;
    bit         slow;

    initial begin
        rst_n = 0;
        zero_inputs();
        model_reset();
        do_reset();

        // Single load with immediate ack
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t1_c0_stall", core_stall, 1'b1);
        chk1("t1_c0_req", mem_req, 1'b0);
        tick_upd();
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h5A);
        chk1("t1_c1_req", mem_req, 1'b1);
        chk8("t1_c1_addr", mem_addr, 8'h10);
        chk1("t1_c1_stall", core_stall, 1'b1);
        tick_upd();
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t1_c2_rvalid", core_rvalid, 1'b1);
        chk8("t1_c2_rdata", core_rdata, 8'h5A);
        chk1("t1_c2_stall", core_stall, 1'b0);
        chk1("t1_c2_req", mem_req, 1'b0);
        tick_upd();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t1_c3_rvalid", core_rvalid, 1'b0);
        tick_upd();

        // Store acked in the third BUSY cycle
        drive(0, 1, 8'h20, 8'hC3, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 8'h20, 8'hC3, 0, 0, 8'h00, 8'h00, logic'(i == 3), 8'hEE);
            chk1("t2_we", mem_we, 1'b1);
            chk8("t2_addr", mem_addr, 8'h20);
            chk8("t2_wdata", mem_wdata, 8'hC3);
            tick_upd();
        end
        drive(0, 1, 8'h20, 8'hC3, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t2_rvalid", core_rvalid, 1'b0);
        chk1("t2_stall", core_stall, 1'b0);
        chk8("t2_rdata_held", core_rdata, 8'h5A);
        tick_upd();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();

        // Load and store together: performed as a read, err raised
        drive(1, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();
        drive(1, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00, 1, 8'h3C);
        chk1("t6_we", mem_we, 1'b0);
        chk1("t6_err", err, 1'b1);
        tick_upd();
        drive(1, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t6_rvalid", core_rvalid, 1'b1);
        chk8("t6_rdata", core_rdata, 8'h3C);
        tick_upd();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();

        do_reset();
        chk1("rst_err_cleared", err, 1'b0);

        // Persistent core and debug requests alternate owners
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 8'h50, 8'h00, 1, 0, 8'h30, 8'h00, 0, 8'h00);
            tick_upd();
            drive(1, 0, 8'h50, 8'h00, 1, 0, 8'h30, 8'h00, 1, 8'(8'h60 + k));
            chk8("t3_grant_addr", mem_addr, (k % 2 == 0) ? 8'h50 : 8'h30);
            tick_upd();
            drive(1, 0, 8'h50, 8'h00, 1, 0, 8'h30, 8'h00, 0, 8'h00);
            chk1("t3_rvalid", core_rvalid, logic'(k % 2 == 0));
            chk1("t3_done", dbg_done, logic'(k % 2 == 1));
            tick_upd();
        end
        chk8("t3_dbg_rdata", dbg_rdata, 8'h63);
        chk8("t3_core_rdata", core_rdata, 8'h62);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();

        // No ack: abort after TO BUSY cycles
        drive(1, 0, 8'h70, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();
        for (int i = 1; i <= TO; i++) begin
            drive(1, 0, 8'h70, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
            chk1("t4_req_held", mem_req, 1'b1);
            tick_upd();
        end
        drive(1, 0, 8'h70, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t4_req_drop", mem_req, 1'b0);
        chk1("t4_rvalid", core_rvalid, 1'b1);
        chk8("t4_rdata", core_rdata, 8'hFF);
        chk1("t4_err", err, 1'b1);
        tick_upd();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h00);
        chk1("t4_err_sticky", err, 1'b1);
        tick_upd();

        // Reset during BUSY, then a fresh load
        drive(1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();
        drive(1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t5_req_busy", mem_req, 1'b1);
        rst_n = 0;
        zero_inputs();
        #1;
        chk1("t5_req_async", mem_req, 1'b0);
        chk1("t5_err_clr", err, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk1("t5_no_rvalid", core_rvalid, 1'b0);
        chk1("t5_no_done", dbg_done, 1'b0);
        rst_n = 1;
        drive(1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick_upd();
        drive(1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5);
        chk8("t5_addr", mem_addr, 8'h12);
        tick_upd();
        drive(1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk1("t5_rvalid", core_rvalid, 1'b1);
        chk8("t5_rdata", core_rdata, 8'hA5);
        tick_upd();

        // Randomized traffic with fast and slow memory phases
        c_pend = 0; d_pend = 0;
        p_cl = 0; p_cs = 0; p_ca = 8'h00; p_cw = 8'h00;
        p_dr = 0; p_dwe = 0; p_da = 8'h00; p_dwd = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if (core_released) c_pend = 0;
            if (dbg_released) d_pend = 0;
            if (!c_pend) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = int'($urandom_range(0, 15));
                    c_pend = 1;
                    p_cl = (r < 8) || (r == 15);
                    p_cs = (r >= 8);
                    p_ca = 8'($urandom);
                    p_cw = 8'($urandom);
                end else begin
                    p_cl = 0; p_cs = 0; p_ca = 8'h00; p_cw = 8'h00;
                end
            end
            if (!d_pend) begin
                if ($urandom_range(0, 3) == 0) begin
                    d_pend = 1; p_dr = 1;
                    p_dwe = logic'($urandom_range(0, 1));
                    p_da = 8'($urandom);
                    p_dwd = 8'($urandom);
                end else begin
                    p_dr = 0; p_dwe = 0; p_da = 8'h00; p_dwd = 8'h00;
                end
            end
            slow = ((n / 500) % 2) == 1;
            if (e_mem_req) p_ack = ($urandom_range(0, slow ? 9 : 1) == 0);
            else p_ack = ($urandom_range(0, 3) == 0);
            drive(p_cl, p_cs, p_ca, p_cw, p_dr, p_dwe, p_da, p_dwd, p_ack, 8'($urandom));
            tick_upd();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
